// File: rtl/ddr_app_scheduler_if.sv
// Bus bundle for ddr_app_scheduler: system-side command / write-beat / read-beat
// ports plus the DDR2 controller native app ports.
// slave  = scheduler view, master = system + controller model view.
interface ddr_app_scheduler_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 64
) ();
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_write_i;
  logic [ADDR_WIDTH-1:0]   cmd_address_i;
  logic                    wdata_valid_i;
  logic                    wdata_ready_o;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH/8-1:0] wmask_i;
  logic                    rdata_valid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    rdata_last_o;
  logic                    app_en_o;
  logic [2:0]              app_cmd_o;
  logic [ADDR_WIDTH-1:0]   app_addr_o;
  logic                    app_rdy_i;
  logic                    app_wdf_wren_o;
  logic [DATA_WIDTH-1:0]   app_wdf_data_o;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask_o;
  logic                    app_wdf_end_o;
  logic                    app_wdf_rdy_i;
  logic [DATA_WIDTH-1:0]   app_rd_data_i;
  logic                    app_rd_data_valid_i;
  logic                    app_rd_data_end_i;

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_address_i,
    input  wdata_valid_i, wdata_i, wmask_i,
    input  app_rdy_i, app_wdf_rdy_i,
    input  app_rd_data_i, app_rd_data_valid_i, app_rd_data_end_i,
    output cmd_ready_o, wdata_ready_o,
    output rdata_valid_o, rdata_o, rdata_last_o,
    output app_en_o, app_cmd_o, app_addr_o,
    output app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_address_i,
    output wdata_valid_i, wdata_i, wmask_i,
    output app_rdy_i, app_wdf_rdy_i,
    output app_rd_data_i, app_rd_data_valid_i, app_rd_data_end_i,
    input  cmd_ready_o, wdata_ready_o,
    input  rdata_valid_o, rdata_o, rdata_last_o,
    input  app_en_o, app_cmd_o, app_addr_o,
    input  app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o
  );
endinterface

// File: rtl/ddr_app_scheduler.sv
// ddr_app_scheduler: command FIFO + issue FSM in front of a DDR2 native app
// interface, write-beat credit metering, in-flight read cap, registered read return.
// Optional: define DDR_APP_SCHEDULER_MASK_EN to forward wmask_i to app_wdf_mask_o;
// otherwise every byte is written.
module ddr_app_scheduler #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 2,
  parameter int CMD_DEPTH  = 8,
  parameter int MAX_READS  = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               init_calib_complete_i,
  ddr_app_scheduler_if.slave bus,
  output logic               idle_o,
  output logic               rd_error_o
);
  localparam int PW   = $clog2(CMD_DEPTH);
  localparam int CNTW = $clog2(CMD_DEPTH + 1);
  localparam int CRW  = $clog2(CMD_DEPTH * BEATS + BEATS + 1);
  localparam int BCW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RFW  = $clog2(MAX_READS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   mem_q [CMD_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [CRW-1:0]        credit_q, credit_d;
  logic [BCW-1:0]        beat_q;
  logic [RFW-1:0]        inflight_q;
  logic                  rd_error_q, rdv_q, rdl_q;
  logic [DATA_WIDTH-1:0] rdd_q;

  logic                  empty, full, push, pop, rd_pop, rd_done, rd_dec;
  logic                  head_wr, rd_full, rd_blocked, credit_ok, beat_acc;
  logic [ADDR_WIDTH-1:0] head_addr;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CNTW'(CMD_DEPTH));
  assign push       = bus.cmd_valid_i & ~full;
  assign {head_wr, head_addr} = mem_q[rd_ptr_q];
  assign rd_full    = (inflight_q == RFW'(MAX_READS));
  assign rd_blocked = ~head_wr & rd_full;
  // app_en is decoded from the state but masked the moment the head read would
  // exceed the cap or calibration drops, so no command escapes on the transition cycle.
  assign bus.app_en_o   = (state_q == ISSUE) & ~rd_blocked & init_calib_complete_i;
  assign bus.app_cmd_o  = head_wr ? 3'b000 : 3'b001;
  assign bus.app_addr_o = head_addr;
  assign pop        = bus.app_en_o & bus.app_rdy_i;
  assign rd_pop     = pop & ~head_wr;
  assign rd_done    = bus.app_rd_data_valid_i & bus.app_rd_data_end_i;
  assign rd_dec     = rd_done & (inflight_q != '0);
  assign cnt_d      = cnt_q + CNTW'(push) - CNTW'(pop);
  assign bus.cmd_ready_o = ~full;

  // Write path: beats only flow against credit earned by accepted write commands.
  assign credit_ok          = (credit_q != '0) & init_calib_complete_i;
  assign bus.wdata_ready_o  = bus.app_wdf_rdy_i & credit_ok;
  assign bus.app_wdf_wren_o = bus.wdata_valid_i & credit_ok;
  assign bus.app_wdf_data_o = bus.wdata_i;
  assign bus.app_wdf_end_o  = (beat_q == BCW'(BEATS - 1));
  assign beat_acc           = bus.wdata_valid_i & bus.wdata_ready_o;
  assign credit_d = credit_q + ((push & bus.cmd_write_i) ? CRW'(BEATS) : CRW'(0)) - CRW'(beat_acc);

`ifdef DDR_APP_SCHEDULER_MASK_EN
  assign bus.app_wdf_mask_o = bus.wmask_i;
`else
  logic unused_wmask;
  assign unused_wmask       = ^bus.wmask_i;
  assign bus.app_wdf_mask_o = '0;
`endif

  assign bus.rdata_valid_o = rdv_q;
  assign bus.rdata_o       = rdd_q;
  assign bus.rdata_last_o  = rdl_q;
  assign rd_error_o        = rd_error_q;
  assign idle_o = empty & (credit_q == '0) & (inflight_q == '0) & (state_q == IDLE);

  // FIFO storage: no reset needed, only entries below cnt_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_write_i, bus.cmd_address_i};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Issue FSM: drain the FIFO back-to-back, park in STALL while the read cap is hit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (init_calib_complete_i && !empty) state_q <= ISSUE;
        ISSUE:   if (!init_calib_complete_i)          state_q <= IDLE;
                 else if (pop)                        state_q <= (cnt_d == '0) ? IDLE : ISSUE;
                 else if (rd_blocked)                 state_q <= STALL;
        STALL:   if (!init_calib_complete_i)          state_q <= IDLE;
                 else if (!rd_full)                   state_q <= ISSUE;
        default:                                      state_q <= IDLE;
      endcase
    end
  end

  // Write credit and beat position; the beat position survives calibration loss.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      credit_q <= '0;
      beat_q   <= '0;
    end else begin
      credit_q <= credit_d;
      if (beat_acc) beat_q <= (beat_q == BCW'(BEATS - 1)) ? '0 : beat_q + 1'b1;
    end
  end

  // In-flight read count; an end beat with nothing outstanding is flagged, not counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= '0;
      rd_error_q <= 1'b0;
    end else begin
      if (rd_pop && !rd_dec)      inflight_q <= inflight_q + 1'b1;
      else if (rd_dec && !rd_pop) inflight_q <= inflight_q - 1'b1;
      if (rd_done && inflight_q == '0) rd_error_q <= 1'b1;
    end
  end

  // Read return: one register stage, no backpressure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdv_q <= 1'b0;
      rdl_q <= 1'b0;
      rdd_q <= '0;
    end else begin
      rdv_q <= bus.app_rd_data_valid_i;
      rdl_q <= bus.app_rd_data_end_i;
      rdd_q <= bus.app_rd_data_i;
    end
  end
endmodule

// File: tb/tb_ddr_app_scheduler.sv
// Testbench for ddr_app_scheduler: vector table for the single write burst,
// hand sequences for read cap / full FIFO / calibration loss / unsolicited data,
// then randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_ddr_app_scheduler;
  localparam int AW = 27, DW = 64, MW = DW / 8, BEATS = 2, DEPTH = 8, MAXR = 4;

  logic clk = 1'b0, rst_n = 1'b1, calib = 1'b0;
  logic idle, rd_err;
  int   checks = 0, errors = 0, pops = 0;

  ddr_app_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr_app_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS),
                      .CMD_DEPTH(DEPTH), .MAX_READS(MAXR)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .init_calib_complete_i(calib),
    .bus(bus), .idle_o(idle), .rd_error_o(rd_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] exp_mask(input logic [MW-1:0] m);
`ifdef DDR_APP_SCHEDULER_MASK_EN
    return m;
`else
    return (m & 8'h00);
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cnt_tick();
    if (bus.app_en_o && bus.app_rdy_i) pops++;
    tick();
  endtask

  task automatic cyc();
    @(negedge clk); cnt_tick();
  endtask

  task automatic clear_inputs();
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_address_i = '0;
    bus.wdata_valid_i = 1'b0; bus.wdata_i = '0; bus.wmask_i = '0;
    bus.app_rdy_i = 1'b0; bus.app_wdf_rdy_i = 1'b0;
    bus.app_rd_data_i = '0; bus.app_rd_data_valid_i = 1'b0; bus.app_rd_data_end_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_inputs(); calib = 1'b1; pops = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic cv, cw; logic [AW-1:0] addr; logic wv; logic [DW-1:0] wd; logic [MW-1:0] wm;
    logic en; logic [2:0] cmd; logic [AW-1:0] ea; logic wren, wend, wrdy, idl;
  } vec_t;
  vec_t tbl [5];

  // ---------------- reference model ----------------
  logic [AW:0]   mq [$];
  int            credit_m, infl_m, beat_m, ret_beat;
  logic          prev_v, prev_l;
  logic [DW-1:0] prev_d;

  task automatic rnd_cycle(input bit gen_cmd, input bit drain);
    logic [AW:0] h;
    bus.cmd_valid_i   = gen_cmd && ($urandom_range(0, 2) == 0);
    bus.cmd_write_i   = 1'($urandom_range(0, 1));
    bus.cmd_address_i = AW'($urandom);
    bus.wdata_valid_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.wdata_i       = {$urandom, $urandom};
    bus.wmask_i       = MW'($urandom);
    bus.app_rdy_i     = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.app_wdf_rdy_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (infl_m > 0 && (drain || $urandom_range(0, 1) == 1)) begin
      bus.app_rd_data_valid_i = 1'b1;
      bus.app_rd_data_end_i   = (ret_beat == BEATS - 1);
    end else begin
      bus.app_rd_data_valid_i = 1'b0;
      bus.app_rd_data_end_i   = 1'b0;
    end
    bus.app_rd_data_i = {$urandom, $urandom};
    @(negedge clk);
    chk("rnd cmd_ready", bus.cmd_ready_o, mq.size() < DEPTH);
    chk("rnd wdata_ready", bus.wdata_ready_o, bus.app_wdf_rdy_i && credit_m != 0);
    chk("rnd wren", bus.app_wdf_wren_o, bus.wdata_valid_i && credit_m != 0);
    if (bus.app_wdf_wren_o) begin
      chk("rnd wdf_end", bus.app_wdf_end_o, beat_m == BEATS - 1);
      chk("rnd wdf_data", bus.app_wdf_data_o, bus.wdata_i);
      chk("rnd wdf_mask", bus.app_wdf_mask_o, exp_mask(bus.wmask_i));
    end
    if (bus.app_en_o) begin
      chk("rnd app_en queue nonempty", mq.size() != 0, 1'b1);
      if (mq.size() != 0) begin
        h = mq[0];
        chk("rnd app_cmd", bus.app_cmd_o, h[AW] ? 3'b000 : 3'b001);
        chk("rnd app_addr", bus.app_addr_o, h[AW-1:0]);
        if (!h[AW]) chk("rnd read cap", infl_m < MAXR, 1'b1);
      end
    end
    chk("rnd rdata_valid", bus.rdata_valid_o, prev_v);
    if (prev_v) begin
      chk("rnd rdata", bus.rdata_o, prev_d);
      chk("rnd rdata_last", bus.rdata_last_o, prev_l);
    end
    chk("rnd idle", idle, mq.size() == 0 && credit_m == 0 && infl_m == 0);
    chk("rnd rd_error", rd_err, 1'b0);
    // commit what the coming edge will do
    if (bus.app_en_o && bus.app_rdy_i && mq.size() != 0) begin
      h = mq.pop_front();
      if (!h[AW]) infl_m++;
    end
    if (bus.cmd_valid_i && bus.cmd_ready_o) begin
      mq.push_back({bus.cmd_write_i, bus.cmd_address_i});
      if (bus.cmd_write_i) credit_m += BEATS;
    end
    if (bus.wdata_valid_i && bus.wdata_ready_o) begin
      credit_m--;
      beat_m = (beat_m + 1) % BEATS;
    end
    if (bus.app_rd_data_valid_i) begin
      if (bus.app_rd_data_end_i) begin infl_m--; ret_beat = 0; end
      else ret_beat++;
    end
    prev_v = bus.app_rd_data_valid_i;
    prev_l = bus.app_rd_data_end_i;
    prev_d = bus.app_rd_data_i;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    #5;
    chk("reset cmd_ready", bus.cmd_ready_o, 1'b1);
    chk("reset idle", idle, 1'b1);
    chk("reset app_en", bus.app_en_o, 1'b0);
    chk("reset wren", bus.app_wdf_wren_o, 1'b0);
    chk("reset wdata_ready", bus.wdata_ready_o, 1'b0);
    chk("reset rdata_valid", bus.rdata_valid_o, 1'b0);
    chk("reset rdata_last", bus.rdata_last_o, 1'b0);
    chk("reset rd_error", rd_err, 1'b0);

    // ---- single write burst, table-driven ----
    tbl[0] = '{1'b1, 1'b1, 27'h100, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD, 8'h00,
               1'b0, 3'b000, 27'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 27'h0, 1'b1, 64'hAAAA_0000_1111_2222, 8'hF0,
               1'b0, 3'b000, 27'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 27'h0, 1'b1, 64'hBBBB_3333_4444_5555, 8'h0F,
               1'b1, 3'b000, 27'h100, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 27'h0, 1'b1, 64'hCCCC_6666_7777_8888, 8'h00,
               1'b0, 3'b000, 27'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 27'h0, 1'b0, 64'h0, 8'h00,
               1'b0, 3'b000, 27'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid_i = tbl[i].cv; bus.cmd_write_i = tbl[i].cw; bus.cmd_address_i = tbl[i].addr;
      bus.wdata_valid_i = tbl[i].wv; bus.wdata_i = tbl[i].wd; bus.wmask_i = tbl[i].wm;
      @(negedge clk);
      chk($sformatf("vec%0d app_en", i), bus.app_en_o, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("vec%0d app_cmd", i), bus.app_cmd_o, tbl[i].cmd);
        chk($sformatf("vec%0d app_addr", i), bus.app_addr_o, tbl[i].ea);
      end
      chk($sformatf("vec%0d wren", i), bus.app_wdf_wren_o, tbl[i].wren);
      chk($sformatf("vec%0d wdata_ready", i), bus.wdata_ready_o, tbl[i].wrdy);
      chk($sformatf("vec%0d idle", i), idle, tbl[i].idl);
      if (tbl[i].wren) begin
        chk($sformatf("vec%0d wdf_end", i), bus.app_wdf_end_o, tbl[i].wend);
        chk($sformatf("vec%0d wdf_data", i), bus.app_wdf_data_o, tbl[i].wd);
        chk($sformatf("vec%0d wdf_mask", i), bus.app_wdf_mask_o, exp_mask(tbl[i].wm));
      end
      tick();
    end

    // ---- calibration loss mid-burst keeps the beat position ----
    do_reset();
    bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b1; bus.cmd_address_i = 27'h200;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.wdata_valid_i = 1'b1; bus.wdata_i = 64'hD0;
    @(negedge clk);
    chk("calib beat0 ready", bus.wdata_ready_o, 1'b1);
    chk("calib beat0 end", bus.app_wdf_end_o, 1'b0);
    tick();
    calib = 1'b0; bus.wdata_i = 64'hD1;
    @(negedge clk);
    chk("calib low ready", bus.wdata_ready_o, 1'b0);
    chk("calib low wren", bus.app_wdf_wren_o, 1'b0);
    chk("calib low app_en", bus.app_en_o, 1'b0);
    tick(); tick();
    calib = 1'b1;
    @(negedge clk);
    chk("calib back wren", bus.app_wdf_wren_o, 1'b1);
    chk("calib back end", bus.app_wdf_end_o, 1'b1);
    tick();
    bus.wdata_valid_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("calib drained idle", idle, 1'b1);
    tick();

    // ---- read cap: 8 reads, 4 issue, one burst returns, 5th issues ----
    do_reset();
    bus.app_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_address_i = AW'(i * 64);
      @(negedge clk);
      chk($sformatf("reads push%0d ready", i), bus.cmd_ready_o, 1'b1);
      if (bus.app_en_o) chk("read app_cmd", bus.app_cmd_o, 3'b001);
      cnt_tick();
    end
    bus.cmd_valid_i = 1'b0;
    repeat (6) cyc();
    chk("read cap pops", pops, 4);
    @(negedge clk);
    chk("read cap app_en low", bus.app_en_o, 1'b0);
    cnt_tick();
    bus.app_rd_data_valid_i = 1'b1; bus.app_rd_data_end_i = 1'b0; bus.app_rd_data_i = 64'h1111_AAAA;
    cyc();
    bus.app_rd_data_end_i = 1'b1; bus.app_rd_data_i = 64'h2222_BBBB;
    @(negedge clk);
    chk("rd beat0 valid", bus.rdata_valid_o, 1'b1);
    chk("rd beat0 data", bus.rdata_o, 64'h1111_AAAA);
    chk("rd beat0 last", bus.rdata_last_o, 1'b0);
    cnt_tick();
    bus.app_rd_data_valid_i = 1'b0; bus.app_rd_data_end_i = 1'b0;
    @(negedge clk);
    chk("rd beat1 valid", bus.rdata_valid_o, 1'b1);
    chk("rd beat1 data", bus.rdata_o, 64'h2222_BBBB);
    chk("rd beat1 last", bus.rdata_last_o, 1'b1);
    cnt_tick();
    repeat (6) cyc();
    chk("read cap pops after return", pops, 5);
    chk("read cap rd_error", rd_err, 1'b0);

    // ---- full FIFO with app_rdy low ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_address_i = AW'(i);
      @(negedge clk);
      chk($sformatf("fill%0d ready", i), bus.cmd_ready_o, 1'b1);
      tick();
    end
    bus.cmd_address_i = 27'h999;
    @(negedge clk);
    chk("full ready low", bus.cmd_ready_o, 1'b0);
    tick();
    @(negedge clk);
    chk("full 9th held", bus.cmd_ready_o, 1'b0);
    chk("full app_en waiting", bus.app_en_o, 1'b1);
    tick();
    bus.app_rdy_i = 1'b1;
    @(negedge clk);
    chk("full head addr", bus.app_addr_o, 27'h0);
    tick();
    bus.app_rdy_i = 1'b0;
    @(negedge clk);
    chk("full ready after pop", bus.cmd_ready_o, 1'b1);
    tick();
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("full again after 9th", bus.cmd_ready_o, 1'b0);
    tick();

    // ---- unsolicited read data ----
    do_reset();
    bus.app_rd_data_valid_i = 1'b1; bus.app_rd_data_end_i = 1'b1;
    @(negedge clk);
    chk("unsolicited before edge", rd_err, 1'b0);
    tick();
    bus.app_rd_data_valid_i = 1'b0; bus.app_rd_data_end_i = 1'b0;
    @(negedge clk);
    chk("unsolicited rd_error set", rd_err, 1'b1);
    repeat (5) tick();
    chk("unsolicited rd_error sticky", rd_err, 1'b1);
    chk("unsolicited idle", idle, 1'b1);
    rst_n = 1'b0; #1;
    chk("unsolicited cleared by reset", rd_err, 1'b0);

    // ---- randomized traffic against the model ----
    do_reset();
    mq.delete(); credit_m = 0; infl_m = 0; beat_m = 0; ret_beat = 0;
    prev_v = 1'b0; prev_l = 1'b0; prev_d = '0;
    repeat (800) rnd_cycle(1'b1, 1'b0);
    for (int n = 0; n < 400 && (mq.size() != 0 || credit_m != 0 || infl_m != 0); n++)
      rnd_cycle(1'b0, 1'b1);
    chk("drain completed", mq.size() == 0 && credit_m == 0 && infl_m == 0, 1'b1);
    clear_inputs(); bus.app_rdy_i = 1'b1;
    @(negedge clk);
    chk("drain idle", idle, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
